pfc_vsense_reader: RTL and testbench
====================================

Name: pfc_vsense_reader

Overview:
- SPI-style master that acquires the two 24-bit PFC voltage-sense words from an external dual-channel serial ADC.
- Presents them as PFC_InVSense and PFC_OutVSense to the PFC controller.
- Free-runs conversions while enabled and flags a stalled ADC.
- Sits between the board ADC pins and the PFC duty-cycle logic; it is the producer side of the 24-bit sense bus.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range 1..255.
- DRDY_TIMEOUT, 4096: clk cycles to wait for adc_drdy_n low before aborting; legal range 16..65535.
- CONV_PULSE, 2: adc_convst high width in clk cycles; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; high = continuous conversions.
- adc_convst  out  1  conversion start strobe, active high.
- adc_drdy_n  in  1  ADC data ready, active low; asynchronous to clk.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  serial clock; idles low.
- adc_miso  in  1  serial data from ADC.
- PFC_InVSense  out  24  latest channel-0 code (input voltage).
- PFC_OutVSense  out  24  latest channel-1 code (output voltage).
- sample_valid  out  1  one-cycle pulse when both words update.
- timeout_err  out  1  sticky flag for a DRDY timeout.

Behaviour:
- Reset values (asynchronous, taking effect immediately, including mid-frame): adc_convst=0, adc_cs_n=1, adc_sclk=0, PFC_InVSense=0, PFC_OutVSense=0, sample_valid=0, timeout_err=0. State returns to IDLE; all counters and the shift register clear.
- adc_drdy_n passes through a 2-FF synchronizer (reset value 1) before use. adc_miso is not synchronized because it is sampled relative to our own SCLK.
- FSM states:
  - IDLE: if enable=1, go to CONV on the next clk.
  - CONV: adc_convst=1 for exactly CONV_PULSE cycles, then go to WAIT_DRDY.
  - WAIT_DRDY: count cycles. If synced drdy_n=0, go to CS_SETUP. If the count reaches DRDY_TIMEOUT, set timeout_err=1 and go to IDLE; outputs hold their old values and no sample_valid pulse is issued.
  - CS_SETUP: adc_cs_n=0 for CLK_DIV cycles before the first SCLK edge.
  - SHIFT: 48 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
    - adc_miso is sampled on the clk cycle in which adc_sclk goes 0->1.
    - Bit order is MSB first: bits 47..24 are channel 0, bits 23..0 are channel 1.
    - After the 48th high phase, adc_sclk returns low.
  - CS_HOLD: adc_sclk=0 for CLK_DIV cycles, then adc_cs_n=1 and go to UPDATE.
  - UPDATE (1 cycle): load both output registers simultaneously from the 48-bit shift register, pulse sample_valid=1, clear timeout_err, then go to IDLE.
- Outputs change only in UPDATE, so the controller never sees a mixed old/new pair.
- enable falling mid-frame: the current frame completes and updates normally. The FSM then stays in IDLE.
- enable held high: back-to-back frames, with IDLE lasting exactly 1 cycle between frames.
- Frame length from the IDLE exit to sample_valid: 1 + CONV_PULSE + W + CLK_DIV + 96*CLK_DIV + CLK_DIV + 1 cycles, where W is the number of WAIT_DRDY cycles including the 2-cycle sync delay.
- adc_drdy_n is ignored outside WAIT_DRDY. A drdy_n already low on entry to WAIT_DRDY is accepted once the synchronized value shows it.
- Codes are unsigned and passed through unmodified; no scaling and no saturation.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT with CLK_DIV=2 -> adc_cs_n=1, adc_sclk=0, both outputs 0, sample_valid=0 in the same cycle. After release with enable=0, no adc_convst is issued.
- Nominal frame: CLK_DIV=2, ADC model drives 0x999999 then 0x123456 and asserts drdy_n 10 cycles after convst falls.
  - Required: exactly 48 SCLK rising edges.
  - Required: PFC_InVSense=0x999999 and PFC_OutVSense=0x123456 in the same cycle as a single sample_valid pulse.
  - Required: adc_cs_n low for 2+192+2 cycles.
- Timeout: DRDY_TIMEOUT=16, drdy_n held high.
  - Required: timeout_err=1 exactly 16 cycles after entering WAIT_DRDY, outputs unchanged, next adc_convst issued 1 cycle later.
  - A following good frame (data 0x000001/0xFFFFFF) clears timeout_err in the UPDATE cycle.
- Enable drop: deassert enable during SHIFT -> the frame finishes with one sample_valid, and no further adc_convst appears for 1000 cycles.
- Continuous: enable=1 for 3 frames with changing data -> 3 sample_valid pulses, outputs match each frame, and the gap from sample_valid to the next adc_convst rise is 1 cycle.
- Extremes: CLK_DIV=1 and data 0xFFFFFF/0x000000 -> adc_sclk toggles every clk and both words are captured bit-exact.

Source files
------------

// File: rtl/pfc_vsense_reader.sv
// Serial master for the dual-channel PFC voltage-sense ADC: triggers a conversion,
// waits for data ready, clocks out 48 bits and publishes both 24-bit codes atomically.
module pfc_vsense_reader #(
    parameter int CLK_DIV      = 4,
    parameter int DRDY_TIMEOUT = 4096,
    parameter int CONV_PULSE   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        adc_convst,
    input  logic        adc_drdy_n,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    input  logic        adc_miso,
    output logic [23:0] PFC_InVSense,
    output logic [23:0] PFC_OutVSense,
    output logic        sample_valid,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WAIT_DRDY,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        UPDATE
    } state_t;

    localparam logic [15:0] DIV_LAST     = 16'(CLK_DIV - 1);
    localparam logic [15:0] CONV_LAST    = 16'(CONV_PULSE - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(DRDY_TIMEOUT - 1);
    localparam logic [5:0]  LAST_BIT     = 6'd47;

    state_t      state_reg;
    logic [15:0] cnt_reg;
    logic [5:0]  bit_cnt_reg;
    logic [47:0] shift_reg;
    logic [1:0]  drdy_sync_reg;
    logic        convst_reg;
    logic        cs_n_reg;
    logic        sclk_reg;
    logic [23:0] in_vsense_reg;
    logic [23:0] out_vsense_reg;
    logic        sample_valid_reg;
    logic        timeout_err_reg;
    logic        drdy_n_sync;

    // adc_drdy_n is driven from the ADC's own timing, so resynchronise before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drdy_sync_reg <= 2'b11;
        end else begin
            drdy_sync_reg <= {drdy_sync_reg[0], adc_drdy_n};
        end
    end

    assign drdy_n_sync = drdy_sync_reg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            convst_reg       <= 1'b0;
            cs_n_reg         <= 1'b1;
            sclk_reg         <= 1'b0;
            in_vsense_reg    <= '0;
            out_vsense_reg   <= '0;
            sample_valid_reg <= 1'b0;
            timeout_err_reg  <= 1'b0;
        end else begin
            sample_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (enable) begin
                        convst_reg <= 1'b1;
                        state_reg  <= CONV;
                    end
                end
                CONV: begin
                    if (cnt_reg == CONV_LAST) begin
                        cnt_reg    <= '0;
                        convst_reg <= 1'b0;
                        state_reg  <= WAIT_DRDY;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                WAIT_DRDY: begin
                    // Data ready wins over a timeout landing on the same cycle.
                    if (!drdy_n_sync) begin
                        cnt_reg   <= '0;
                        cs_n_reg  <= 1'b0;
                        state_reg <= CS_SETUP;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        cnt_reg         <= '0;
                        timeout_err_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                CS_SETUP: begin
                    if (cnt_reg == DIV_LAST) begin
                        cnt_reg     <= '0;
                        bit_cnt_reg <= '0;
                        state_reg   <= SHIFT;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                SHIFT: begin
                    if (cnt_reg == DIV_LAST) begin
                        cnt_reg <= '0;
                        if (!sclk_reg) begin
                            // Capture on the same clk edge that raises SCLK.
                            sclk_reg  <= 1'b1;
                            shift_reg <= {shift_reg[46:0], adc_miso};
                        end else begin
                            sclk_reg <= 1'b0;
                            if (bit_cnt_reg == LAST_BIT) begin
                                state_reg <= CS_HOLD;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 6'd1;
                            end
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                CS_HOLD: begin
                    if (cnt_reg == DIV_LAST) begin
                        cnt_reg          <= '0;
                        cs_n_reg         <= 1'b1;
                        in_vsense_reg    <= shift_reg[47:24];
                        out_vsense_reg   <= shift_reg[23:0];
                        sample_valid_reg <= 1'b1;
                        timeout_err_reg  <= 1'b0;
                        state_reg        <= UPDATE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                UPDATE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign adc_convst    = convst_reg;
    assign adc_cs_n      = cs_n_reg;
    assign adc_sclk      = sclk_reg;
    assign PFC_InVSense  = in_vsense_reg;
    assign PFC_OutVSense = out_vsense_reg;
    assign sample_valid  = sample_valid_reg;
    assign timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_pfc_vsense_reader.sv
// Bench for pfc_vsense_reader: two instances (CLK_DIV=2 and CLK_DIV=1) with a
// behavioural ADC each, and a queue-based scoreboard checking every sample_valid.
module tb_pfc_vsense_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic        enable0 = 1'b0;
    logic        convst0, cs_n0, sclk0, sv0, terr0;
    logic        drdy_n0 = 1'b1;
    logic        miso0 = 1'b0;
    logic [23:0] in0, out0;

    logic        enable1 = 1'b0;
    logic        convst1, cs_n1, sclk1, sv1, terr1;
    logic        drdy_n1 = 1'b1;
    logic        miso1 = 1'b0;
    logic [23:0] in1, out1;

    pfc_vsense_reader #(.CLK_DIV(2), .DRDY_TIMEOUT(16), .CONV_PULSE(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable0), .adc_convst(convst0),
        .adc_drdy_n(drdy_n0), .adc_cs_n(cs_n0), .adc_sclk(sclk0), .adc_miso(miso0),
        .PFC_InVSense(in0), .PFC_OutVSense(out0), .sample_valid(sv0), .timeout_err(terr0)
    );

    pfc_vsense_reader #(.CLK_DIV(1), .DRDY_TIMEOUT(64), .CONV_PULSE(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable1), .adc_convst(convst1),
        .adc_drdy_n(drdy_n1), .adc_cs_n(cs_n1), .adc_sclk(sclk1), .adc_miso(miso1),
        .PFC_InVSense(in1), .PFC_OutVSense(out1), .sample_valid(sv1), .timeout_err(terr1)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [47:0] adc_q0[$], adc_q1[$], exp_q0[$], exp_q1[$];
    logic [47:0] frame0, frame1, exp_e0, exp_e1;
    logic        stall0 = 1'b0;
    int          bit0, bit1, rises0, rises1, cslow0, cslow1;
    int          convst_cnt0 = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic probe(input int which);
        case (which)
            0:       return sv0;
            1:       return convst0;
            2:       return sclk0;
            3:       return !convst0;
            4:       return sv1;
            5:       return convst1;
            6:       return sclk1;
            default: return 1'b0;
        endcase
    endfunction

    // Advances at least one cycle, then waits up to budget cycles for the event.
    task automatic wait_sig(input int which, input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!probe(which) && n < budget);
        if (!probe(which)) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got no event in %0d cycles, expected event", name, budget);
        end
    endtask

    // ADC model, instance 0: data ready 10 cycles after convst falls unless stalled.
    always @(negedge convst0) if (rst_n && !stall0) begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        drdy_n0 = 1'b0;
    end

    always @(negedge cs_n0) if (rst_n) begin
        drdy_n0 = 1'b1;
        if (adc_q0.size() > 0) frame0 = adc_q0.pop_front();
        else frame0 = 48'h0;
        bit0 = 47;
        miso0 = frame0[47];
        rises0 = 0;
        cslow0 = 0;
    end

    always @(negedge sclk0) if (!cs_n0 && bit0 > 0) begin
        bit0--;
        miso0 = frame0[bit0];
    end

    always @(posedge sclk0) if (!cs_n0) rises0++;
    always @(negedge clk) if (!cs_n0) cslow0++;
    always @(posedge convst0) convst_cnt0++;

    always @(posedge cs_n0) if (rst_n) begin
        check("sclk_rises0", 48'(rises0), 48'd48);
        check("cs_low0", 48'(cslow0), 48'd196);
    end

    // ADC model, instance 1.
    always @(negedge convst1) if (rst_n) begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        drdy_n1 = 1'b0;
    end

    always @(negedge cs_n1) if (rst_n) begin
        drdy_n1 = 1'b1;
        if (adc_q1.size() > 0) frame1 = adc_q1.pop_front();
        else frame1 = 48'h0;
        bit1 = 47;
        miso1 = frame1[47];
        rises1 = 0;
        cslow1 = 0;
    end

    always @(negedge sclk1) if (!cs_n1 && bit1 > 0) begin
        bit1--;
        miso1 = frame1[bit1];
    end

    always @(posedge sclk1) if (!cs_n1) rises1++;
    always @(negedge clk) if (!cs_n1) cslow1++;

    always @(posedge cs_n1) if (rst_n) begin
        check("sclk_rises1", 48'(rises1), 48'd48);
        check("cs_low1", 48'(cslow1), 48'd98);
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (sv0) begin
            $display("dut0 sample in=%06h out=%06h", in0, out0);
            if (exp_q0.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sv0_unexpected: got pulse, expected none");
            end else begin
                exp_e0 = exp_q0.pop_front();
                check("frame0", {in0, out0}, exp_e0);
            end
        end
        if (sv1) begin
            $display("dut1 sample in=%06h out=%06h", in1, out1);
            if (exp_q1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sv1_unexpected: got pulse, expected none");
            end else begin
                exp_e1 = exp_q1.pop_front();
                check("frame1", {in1, out1}, exp_e1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int toggles;
        logic prev;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs_n", 48'(cs_n0), 48'd1);
        check("rst_sclk", 48'(sclk0), 48'd0);
        check("rst_convst", 48'(convst0), 48'd0);
        check("rst_outs", {in0, out0}, 48'h0);
        check("rst_sv", 48'(sv0), 48'd0);
        check("rst_terr", 48'(terr0), 48'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_no_convst", 48'(convst_cnt0), 48'd0);

        // Nominal frame
        adc_q0.push_back(48'h999999_123456);
        exp_q0.push_back(48'h999999_123456);
        enable0 = 1'b1;
        wait_sig(1, 20, "nom_convst");
        enable0 = 1'b0;
        wait_sig(0, 400, "nom_sv");
        @(negedge clk);
        check("nom_sv_width", 48'(sv0), 48'd0);
        check("nom_terr", 48'(terr0), 48'd0);

        // DRDY timeout, then a good frame with enable dropped during SHIFT
        stall0 = 1'b1;
        enable0 = 1'b1;
        wait_sig(1, 20, "to_convst");
        wait_sig(3, 10, "to_convst_fall");
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!terr0 && cnt < 40);
        check("to_latency", 48'(cnt), 48'd16);
        check("to_outs_hold", {in0, out0}, 48'h999999_123456);
        @(negedge clk);
        check("to_reconv", 48'(convst0), 48'd1);
        check("to_sticky", 48'(terr0), 48'd1);
        stall0 = 1'b0;
        adc_q0.push_back(48'h000001_FFFFFF);
        exp_q0.push_back(48'h000001_FFFFFF);
        wait_sig(2, 100, "drop_shift");
        enable0 = 1'b0;
        wait_sig(0, 400, "drop_sv");
        check("clr_terr", 48'(terr0), 48'd0);
        repeat (1000) @(negedge clk);
        check("drop_no_convst", 48'(convst_cnt0), 48'd3);

        // Continuous back-to-back frames
        adc_q0.push_back(48'hABCDEF_012345);
        exp_q0.push_back(48'hABCDEF_012345);
        adc_q0.push_back(48'h800000_7FFFFF);
        exp_q0.push_back(48'h800000_7FFFFF);
        adc_q0.push_back(48'h5A5A5A_A5A5A5);
        exp_q0.push_back(48'h5A5A5A_A5A5A5);
        enable0 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_sig(0, 400, "cont_sv");
            if (f < 2) begin
                @(negedge clk);
                check("cont_gap_idle", 48'(convst0), 48'd0);
                @(negedge clk);
                check("cont_gap_conv", 48'(convst0), 48'd1);
                if (f == 1) enable0 = 1'b0;
            end
        end
        repeat (20) @(negedge clk);
        check("cont_count", 48'(convst_cnt0), 48'd6);

        // CLK_DIV=1 extremes
        adc_q1.push_back(48'hFFFFFF_000000);
        exp_q1.push_back(48'hFFFFFF_000000);
        enable1 = 1'b1;
        wait_sig(5, 20, "ext_convst");
        enable1 = 1'b0;
        wait_sig(6, 100, "ext_sclk");
        toggles = 0;
        prev = sclk1;
        for (int i = 0; i < 95; i++) begin
            @(negedge clk);
            if (sclk1 != prev) toggles++;
            prev = sclk1;
        end
        check("ext_toggle", 48'(toggles), 48'd95);
        wait_sig(4, 100, "ext_sv");
        check("ext_terr", 48'(terr1), 48'd0);

        // Asynchronous reset in the middle of SHIFT
        enable0 = 1'b1;
        wait_sig(1, 20, "mid_convst");
        enable0 = 1'b0;
        wait_sig(2, 100, "mid_shift");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_cs_n", 48'(cs_n0), 48'd1);
        check("mid_sclk", 48'(sclk0), 48'd0);
        check("mid_outs", {in0, out0}, 48'h0);
        check("mid_sv", 48'(sv0), 48'd0);
        check("mid_convst", 48'(convst0), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("mid_no_convst", 48'(convst_cnt0), 48'd7);

        check("q0_drained", 48'(exp_q0.size()), 48'd0);
        check("q1_drained", 48'(exp_q1.size()), 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
